// File: rtl/ofdm_symbol_framer.sv
// OFDM frame sequencer: opens an nsym-symbol window on sync_start and re-frames the sample stream per symbol.
// Define OFDM_FRAMER_CP_STRIP_EN to drop cyclic-prefix samples and emit only the FFT_LEN useful samples.
module ofdm_symbol_framer #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CP_LEN  = 256,
   parameter int unsigned FFT_LEN = 1024,
   parameter int unsigned CNT_W   = 16
) (
   input  logic              clock_clk,
   input  logic              reset_reset_n,
   input  logic              sync_start,
   input  logic [7:0]        cfg_nsym,
   input  logic [DATA_W-1:0] asi_in0_data,
   input  logic              asi_in0_valid,
   output logic              asi_in0_ready,
   output logic [DATA_W-1:0] aso_out0_data,
   output logic              aso_out0_valid,
   input  logic              aso_out0_ready,
   output logic              aso_out0_startofpacket,
   output logic              aso_out0_endofpacket,
   output logic              busy,
   output logic [7:0]        sym_index,
   output logic              frame_done,
   output logic              err_sync_busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(CP_LEN + FFT_LEN - 1);

   state_t           state, state_nxt;
   logic [7:0]       nsym;
   logic [CNT_W-1:0] samp_cnt;
   logic             in_beat, out_beat, load, fwd;
   logic             samp_last, sym_last, frame_end, sync_accept;
   logic [CNT_W-1:0] sop_samp;

`ifdef OFDM_FRAMER_CP_STRIP_EN
   // CP samples are consumed under the normal handshake but never reach the output register.
   assign fwd      = (samp_cnt >= CNT_W'(CP_LEN));
   assign sop_samp = CNT_W'(CP_LEN);
`else
   assign fwd      = 1'b1;
   assign sop_samp = '0;
`endif

   assign in_beat     = asi_in0_valid & asi_in0_ready;
   assign out_beat    = aso_out0_valid & aso_out0_ready;
   assign samp_last   = (samp_cnt == LAST_SAMP);
   assign sym_last    = (sym_index == (nsym - 8'd1));
   assign load        = in_beat && (state == RUN) && fwd;
   assign frame_end   = (state == DRAIN) && out_beat && aso_out0_endofpacket;
   assign sync_accept = (state == IDLE) && sync_start && (cfg_nsym != 8'd0);

   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) state <= IDLE;
      else                state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (sync_accept) state_nxt = RUN;
         RUN:     if (in_beat && samp_last && sym_last) state_nxt = DRAIN;
         DRAIN:   if (frame_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      asi_in0_ready = 1'b0;
      busy          = 1'b0;
      unique case (state)
         IDLE:    asi_in0_ready = reset_reset_n;
         RUN: begin
            asi_in0_ready = !aso_out0_valid | aso_out0_ready;
            busy          = 1'b1;
         end
         DRAIN:   busy = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         nsym          <= '0;
         samp_cnt      <= '0;
         sym_index     <= '0;
         frame_done    <= 1'b0;
         err_sync_busy <= 1'b0;
      end else begin
         frame_done <= frame_end;
         if (sync_accept) begin
            nsym          <= cfg_nsym;
            samp_cnt      <= '0;
            sym_index     <= '0;
            err_sync_busy <= 1'b0;
         end else if (sync_start && (state != IDLE)) begin
            err_sync_busy <= 1'b1;
         end
         if (in_beat && (state == RUN)) begin
            if (samp_last) begin
               samp_cnt  <= '0;
               sym_index <= sym_index + 8'd1;
            end else begin
               samp_cnt <= samp_cnt + 1'b1;
            end
         end
         if (frame_end) sym_index <= '0;
      end
   end

   // One-deep output register; contents hold while stalled.
   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         aso_out0_data          <= '0;
         aso_out0_valid         <= 1'b0;
         aso_out0_startofpacket <= 1'b0;
         aso_out0_endofpacket   <= 1'b0;
      end else if (load) begin
         aso_out0_data          <= asi_in0_data;
         aso_out0_valid         <= 1'b1;
         aso_out0_startofpacket <= (samp_cnt == sop_samp);
         aso_out0_endofpacket   <= samp_last;
      end else if (out_beat) begin
         aso_out0_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ofdm_symbol_framer.sv
// Self-checking bench for ofdm_symbol_framer against a frame-level reference model.
// Honours OFDM_FRAMER_CP_STRIP_EN so the same bench covers both builds.
module tb_ofdm_symbol_framer;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CP_LEN  = 256;
   localparam int unsigned FFT_LEN = 1024;
   localparam int unsigned SYM_LEN = CP_LEN + FFT_LEN;
`ifdef OFDM_FRAMER_CP_STRIP_EN
   localparam int unsigned FIRST = CP_LEN;
`else
   localparam int unsigned FIRST = 0;
`endif
   localparam int unsigned OUT_PER_SYM = SYM_LEN - FIRST;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sync_start;
   logic [7:0]        cfg_nsym;
   logic [DATA_W-1:0] in_data;
   logic              in_valid, in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid, out_ready, out_sop, out_eop;
   logic              busy, frame_done, err_sync_busy;
   logic [7:0]        sym_index;

   ofdm_symbol_framer #(.DATA_W(DATA_W), .CP_LEN(CP_LEN), .FFT_LEN(FFT_LEN), .CNT_W(16)) dut (
      .clock_clk(clk), .reset_reset_n(rst_n), .sync_start(sync_start), .cfg_nsym(cfg_nsym),
      .asi_in0_data(in_data), .asi_in0_valid(in_valid), .asi_in0_ready(in_ready),
      .aso_out0_data(out_data), .aso_out0_valid(out_valid), .aso_out0_ready(out_ready),
      .aso_out0_startofpacket(out_sop), .aso_out0_endofpacket(out_eop),
      .busy(busy), .sym_index(sym_index), .frame_done(frame_done), .err_sync_busy(err_sync_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] d;
      bit                sop;
      bit                eop;
   } beat_t;

   beat_t       q[$];
   int unsigned n_checks = 0, n_err = 0;
   bit          m_rst, m_active, m_err, m_fd;
   int unsigned m_cnt, m_total;
   int unsigned n_out = 0, n_sop = 0, n_eop = 0, n_fd = 0;
   bit          rnd_in = 1'b0, rnd_out = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_sop_eop"}, {out_sop, out_eop}, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_sym_index"}, sym_index, 0);
      chk({tag, "_frame_done"}, frame_done, 0);
      chk({tag, "_err"}, err_sync_busy, 0);
   endtask

   // One clock: check DUT against the model, advance the model across the edge, drive new inputs.
   task automatic cyc();
      bit          drain, exp_ready, done, nxt_fd;
      int unsigned pos;
      @(negedge clk);
      if (m_rst) begin
         chk_all_zero("reset");
      end else begin
         drain     = m_active && (m_cnt == m_total);
         exp_ready = !m_active ? 1'b1 : (drain ? 1'b0 : (q.size() == 0 || out_ready));
         chk("out_valid", out_valid, q.size() != 0);
         if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_sop", out_sop, q[0].sop);
            chk("out_eop", out_eop, q[0].eop);
         end
         chk("in_ready", in_ready, exp_ready);
         chk("busy", busy, m_active);
         chk("frame_done", frame_done, m_fd);
         chk("err_sync_busy", err_sync_busy, m_err);
         if (!drain) chk("sym_index", sym_index, m_active ? m_cnt / SYM_LEN : 0);
         done   = 1'b0;
         nxt_fd = 1'b0;
         if (q.size() != 0 && out_ready) begin
            n_out++;
            if (q[0].sop) n_sop++;
            if (q[0].eop) n_eop++;
            if (q[0].eop && drain) begin
               done   = 1'b1;
               nxt_fd = 1'b1;
            end
            void'(q.pop_front());
         end
         if (in_valid && exp_ready && m_active && !drain) begin
            pos = m_cnt % SYM_LEN;
            if (pos >= FIRST) q.push_back('{in_data, pos == FIRST, pos == SYM_LEN - 1});
            m_cnt++;
         end
         if (sync_start) begin
            if (!m_active) begin
               if (cfg_nsym != 0) begin
                  m_active = 1'b1;
                  m_cnt    = 0;
                  m_total  = cfg_nsym * SYM_LEN;
                  m_err    = 1'b0;
               end
            end else begin
               m_err = 1'b1;
            end
         end
         if (done) m_active = 1'b0;
         m_fd = nxt_fd;
         if (nxt_fd) n_fd++;
      end
      @(posedge clk);
      #1;
      sync_start = 1'b0;
      in_data    = $urandom;
      in_valid   = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready  = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic model_reset();
      m_rst    = 1'b1;
      m_active = 1'b0;
      m_err    = 1'b0;
      m_fd     = 1'b0;
      m_cnt    = 0;
      q.delete();
   endtask

   task automatic start_frame(input logic [7:0] n);
      cfg_nsym   = n;
      sync_start = 1'b1;
      cyc();
   endtask

   task automatic run_to_done(input string tag, input int unsigned limit);
      int unsigned k = 0;
      int unsigned fd0 = n_fd;
      while (n_fd == fd0 && k < limit) begin
         cyc();
         k++;
      end
      chk({tag, "_done_seen"}, n_fd != fd0, 1);
      cyc();
      cyc();
   endtask

   task automatic run_to_sample(input string tag, input int unsigned s, input int unsigned limit);
      int unsigned k = 0;
      while (m_cnt < s && k < limit) begin
         cyc();
         k++;
      end
      chk({tag, "_reached"}, m_cnt >= s, 1);
   endtask

   initial begin
      int unsigned o0, s0, e0, f0;
      rst_n = 1'b0; sync_start = 1'b0; cfg_nsym = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
      model_reset();
      repeat (3) cyc();
      rst_n = 1'b1; m_rst = 1'b0;

      // Samples with no frame open are dropped.
      o0 = n_out;
      repeat (100) cyc();
      chk("idle_no_output", n_out - o0, 0);

      // Two-symbol frame, full throughput.
      o0 = n_out; s0 = n_sop; e0 = n_eop; f0 = n_fd;
      start_frame(8'd2);
      run_to_done("frame2", 3000);
      chk("frame2_beats", n_out - o0, 2 * OUT_PER_SYM);
      chk("frame2_sop", n_sop - s0, 2);
      chk("frame2_eop", n_eop - e0, 2);
      chk("frame2_fd", n_fd - f0, 1);

      // One symbol with random valid and backpressure.
      rnd_in = 1'b1; rnd_out = 1'b1;
      o0 = n_out;
      start_frame(8'd1);
      run_to_done("stall", 20000);
      chk("stall_beats", n_out - o0, OUT_PER_SYM);
      rnd_in = 1'b0; rnd_out = 1'b0;

      // Sync while busy: frame continues, error sticks until the next accepted sync.
      o0 = n_out;
      start_frame(8'd3);
      run_to_sample("busy_sync", 500, 1000);
      sync_start = 1'b1;
      cyc();
      run_to_done("busy_sync", 6000);
      chk("busy_sync_beats", n_out - o0, 3 * OUT_PER_SYM);
      chk("err_sticky", err_sync_busy, 1);
      start_frame(8'd0);
      repeat (5) cyc();
      chk("err_after_nsym0", err_sync_busy, 1);
      rnd_out = 1'b1;
      start_frame(8'd1);
      run_to_done("after_err", 6000);
      rnd_out = 1'b0;

      // Reset mid-frame aborts immediately.
      start_frame(8'd2);
      run_to_sample("abort", 700, 1000);
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort_now");
      model_reset();
      repeat (2) cyc();
      rst_n = 1'b1; m_rst = 1'b0;
      cyc();
      o0 = n_out; s0 = n_sop;
      start_frame(8'd1);
      run_to_done("restart", 3000);
      chk("restart_beats", n_out - o0, OUT_PER_SYM);
      chk("restart_sop", n_sop - s0, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
